// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
//
// Schedules a small pool of obstacle slots for a side-scrolling game. Each
// game tick (update pulse) starts one scheduling pass: every slot is moved
// or retired, one slot per clock. Then a new obstacle may be spawned into
// the lowest free slot. Finally the pass reports how many obstacles left
// the screen.
//
// Build option:
//   OBSTACLE_ANIMATION_EN - when defined, surviving obstacles with sprite
//                           Id 6 or 7 swap between 6 and 7 on every pass.
//                           When undefined, Id keeps its spawn value.
//
// Ports:
//   clock        system clock; all logic runs on its rising edge
//   reset        synchronous, active-low reset
//   update       one-clock game tick; starts a pass when the block is idle
//   gameSpeed    pixels moved per tick
//   randomSeed   LFSR seed, sampled once right after reset
//   xObstacle    packed per-slot lane (63 low, 110 high), slot i at [8i+7:8i]
//   yObstacle    packed per-slot y position, slot i at [9i+8:9i]
//   IdObstacle   packed per-slot sprite Id, slot i at [4i+3:4i]
//   active       per-slot occupied flags
//   passed       one-clock pulse at pass end when any slot retired
//   passedCount  saturating count of retired obstacles
//   busy         high while a pass is in progress
module obstacle_scheduler #(
  parameter int NUM_OBSTACLES = 3,
  parameter int SPAWN_Y       = 419,
  parameter int END_Y         = 36,
  parameter int MIN_GAP       = 120
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         update,
  input  logic [8:0]                   gameSpeed,
  input  logic [15:0]                  randomSeed,
  output logic [8*NUM_OBSTACLES-1:0]   xObstacle,
  output logic [9*NUM_OBSTACLES-1:0]   yObstacle,
  output logic [4*NUM_OBSTACLES-1:0]   IdObstacle,
  output logic [NUM_OBSTACLES-1:0]     active,
  output logic                         passed,
  output logic [7:0]                   passedCount,
  output logic                         busy
);

  typedef enum logic [2:0] {
    SEED,
    IDLE,
    MOVE,
    SPAWN,
    DONE
  } stateT;

  localparam logic [7:0]  X_LOW        = 8'd63;
  localparam logic [7:0]  X_HIGH       = 8'd110;
  localparam logic [3:0]  ID_HIGH      = 4'd8;
  localparam logic [3:0]  ID_LOW       = 4'd6;
`ifdef OBSTACLE_ANIMATION_EN
  localparam logic [3:0]  ID_ALT       = 4'd7;
`endif
  localparam logic [8:0]  SPAWN_Y_W    = 9'(SPAWN_Y);
  localparam logic [10:0] END_Y_W      = 11'(END_Y);
  localparam logic [10:0] MIN_GAP_W    = 11'(MIN_GAP);
  localparam logic [3:0]  LAST_SLOT    = 4'(NUM_OBSTACLES - 1);
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [9:0]  GAP_MAX      = 10'h3FF;

  stateT state;
  stateT stateNext;

  logic [7:0]               xReg  [NUM_OBSTACLES];
  logic [8:0]               yReg  [NUM_OBSTACLES];
  logic [3:0]               idReg [NUM_OBSTACLES];
  logic [NUM_OBSTACLES-1:0] activeReg;

  logic [3:0]  slotIdx;
  logic [3:0]  retireCount;
  logic [9:0]  gapAcc;
  logic [15:0] lfsr;

  logic [8:0]  curY;
  logic [10:0] retireLimit;
  logic        retireNow;
  logic [10:0] gapSum;
  logic [9:0]  gapSat;
  logic [10:0] spawnThreshold;
  logic        freeFound;
  logic [3:0]  freeIdx;
  logic        spawnGo;
  logic [15:0] lfsrNext;
  logic [8:0]  pcSum;
  logic [7:0]  pcSat;

  // State register. The reset is synchronous, so it can also abort a pass
  // that is already running and send the block back through SEED.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= SEED;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic. busy is decoded from the state, so it rises on the
  // clock after update is accepted and falls as the pass leaves DONE.
  // update is only looked at in IDLE, which means ticks that arrive
  // during a pass are dropped instead of being queued.
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    case (state)
      SEED:  stateNext = IDLE;
      IDLE:  if (update) stateNext = MOVE;
      MOVE: begin
        busy = 1'b1;
        if (slotIdx == LAST_SLOT) stateNext = SPAWN;
      end
      SPAWN: begin
        busy      = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = SEED;
    endcase
  end

  // Pick the y of the slot being moved this clock. The retire compare is
  // done at 11 bits, so END_Y + 2*gameSpeed cannot wrap even at top speed.
  always_comb begin
    curY = '0;
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      if (slotIdx == 4'(i)) curY = yReg[i];
    end
  end

  assign retireLimit = END_Y_W + {1'b0, gameSpeed, 1'b0};
  assign retireNow   = ({2'b00, curY} <= retireLimit);

  // Spawn decision. The gap accumulator first absorbs this tick's travel
  // and saturates. It is then compared against a randomised threshold
  // built from the current (not yet advanced) LFSR. The free-slot search
  // runs from the top index down, so the lowest free index wins. Slots
  // retired earlier in the same pass already count as free here.
  always_comb begin
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
      if (!activeReg[i]) begin
        freeFound = 1'b1;
        freeIdx   = 4'(i);
      end
    end
  end

  assign gapSum         = {1'b0, gapAcc} + {2'b00, gameSpeed};
  assign gapSat         = gapSum[10] ? GAP_MAX : gapSum[9:0];
  assign spawnThreshold = MIN_GAP_W + {4'b0000, lfsr[3:0], 3'b000};
  assign spawnGo        = ({1'b0, gapSat} >= spawnThreshold) && freeFound;
  assign lfsrNext       = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign pcSum          = {1'b0, passedCount} + {5'b00000, retireCount};
  assign pcSat          = pcSum[8] ? 8'hFF : pcSum[7:0];

  // Slot datapath, LFSR, gap accumulator and pass bookkeeping. The gap
  // resets to its maximum so the very first pass after reset spawns.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OBSTACLES; i++) begin
        xReg[i]  <= X_LOW;
        yReg[i]  <= SPAWN_Y_W;
        idReg[i] <= ID_HIGH;
      end
      activeReg   <= '0;
      passed      <= 1'b0;
      passedCount <= '0;
      gapAcc      <= GAP_MAX;
      lfsr        <= LFSR_DEFAULT;
      slotIdx     <= '0;
      retireCount <= '0;
    end else begin
      passed <= 1'b0;
      case (state)
        SEED: begin
          lfsr <= (randomSeed == 16'h0000) ? LFSR_DEFAULT : randomSeed;
        end
        IDLE: begin
          slotIdx     <= '0;
          retireCount <= '0;
        end
        MOVE: begin
          slotIdx <= slotIdx + 4'd1;
          for (int i = 0; i < NUM_OBSTACLES; i++) begin
            if (slotIdx == 4'(i) && activeReg[i]) begin
              if (retireNow) begin
                activeReg[i] <= 1'b0;
                retireCount  <= retireCount + 4'd1;
              end else begin
                yReg[i] <= yReg[i] - gameSpeed;
`ifdef OBSTACLE_ANIMATION_EN
                if (idReg[i] == ID_LOW) begin
                  idReg[i] <= ID_ALT;
                end else if (idReg[i] == ID_ALT) begin
                  idReg[i] <= ID_LOW;
                end
`endif
              end
            end
          end
        end
        SPAWN: begin
          lfsr <= lfsrNext;
          if (spawnGo) begin
            gapAcc <= '0;
            for (int i = 0; i < NUM_OBSTACLES; i++) begin
              if (freeIdx == 4'(i)) begin
                activeReg[i] <= 1'b1;
                yReg[i]      <= SPAWN_Y_W;
                xReg[i]      <= lfsr[0] ? X_HIGH : X_LOW;
                idReg[i]     <= lfsr[0] ? ID_HIGH : ID_LOW;
              end
            end
          end else begin
            gapAcc <= gapSat;
          end
        end
        DONE: begin
          passed      <= (retireCount != 4'd0);
          passedCount <= pcSat;
        end
        default: ;
      endcase
    end
  end

  // Flatten the per-slot registers onto the packed output buses.
  for (genvar g = 0; g < NUM_OBSTACLES; g++) begin : gPack
    assign xObstacle[8*g +: 8]  = xReg[g];
    assign yObstacle[9*g +: 9]  = yReg[g];
    assign IdObstacle[4*g +: 4] = idReg[g];
  end

  assign active = activeReg;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler
//
// Self-checking bench for obstacle_scheduler. A behavioural model of the
// game rules predicts the slot table at the end of every pass. The
// prediction is queued when the tick is issued. A monitor pops and compares
// it when the DUT drops busy. Stimulus is randomised speeds, random idle
// gaps and stray ticks during a pass. The bench also applies a reset in
// the middle of a pass and reseeds the LFSR afterwards.
module tb_obstacle_scheduler;

  localparam int N       = 3;
  localparam int SPAWN_Y = 419;
  localparam int END_Y   = 36;
  localparam int MIN_GAP = 120;

  logic           clock;
  logic           reset;
  logic           update;
  logic [8:0]     gameSpeed;
  logic [15:0]    randomSeed;
  logic [8*N-1:0] xObstacle;
  logic [9*N-1:0] yObstacle;
  logic [4*N-1:0] IdObstacle;
  logic [N-1:0]   active;
  logic           passed;
  logic [7:0]     passedCount;
  logic           busy;

  obstacle_scheduler #(
    .NUM_OBSTACLES(N),
    .SPAWN_Y(SPAWN_Y),
    .END_Y(END_Y),
    .MIN_GAP(MIN_GAP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .update(update),
    .gameSpeed(gameSpeed),
    .randomSeed(randomSeed),
    .xObstacle(xObstacle),
    .yObstacle(yObstacle),
    .IdObstacle(IdObstacle),
    .active(active),
    .passed(passed),
    .passedCount(passedCount),
    .busy(busy)
  );

  // 100 MHz clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [8*N-1:0] x;
    logic [9*N-1:0] y;
    logic [4*N-1:0] id;
    logic [N-1:0]   act;
    logic           passed;
    logic [7:0]     pc;
  } expT;

  expT expQ[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Reference model state: plain integers per slot
  int mX[N];
  int mY[N];
  int mId[N];
  bit mAct[N];
  int mLfsr;
  int mGap;
  int mPc;

  // One comparison; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Right-shifting Galois LFSR step for the polynomial x^16+x^14+x^13+x^11+1
  function automatic int galoisStep(input int v);
    int r;
    r = v >> 1;
    if ((v & 1) != 0) r = r ^ 'hB400;
    return r & 'hFFFF;
  endfunction

  task automatic modelReset(input int seed);
    for (int i = 0; i < N; i++) begin
      mX[i]   = 63;
      mY[i]   = SPAWN_Y;
      mId[i]  = 8;
      mAct[i] = 1'b0;
    end
    mLfsr = (seed == 0) ? 'hACE1 : seed;
    mGap  = 1023;
    mPc   = 0;
  endtask

  function automatic expT snapshot(input bit p);
    expT e;
    for (int i = 0; i < N; i++) begin
      e.x[8*i +: 8]  = 8'(mX[i]);
      e.y[9*i +: 9]  = 9'(mY[i]);
      e.id[4*i +: 4] = 4'(mId[i]);
      e.act[i]       = mAct[i];
    end
    e.passed = p;
    e.pc     = 8'(mPc);
    return e;
  endfunction

  function automatic expT resetRecord();
    expT e;
    for (int i = 0; i < N; i++) begin
      e.x[8*i +: 8]  = 8'd63;
      e.y[9*i +: 9]  = 9'(SPAWN_Y);
      e.id[4*i +: 4] = 4'd8;
    end
    e.act    = '0;
    e.passed = 1'b0;
    e.pc     = 8'd0;
    return e;
  endfunction

  // One game tick under the rules: move or retire, then maybe spawn
  task automatic modelPass(input int speed, output expT e);
    int ret;
    int thr;
    int freeSlot;
    ret = 0;
    for (int i = 0; i < N; i++) begin
      if (mAct[i]) begin
        if (mY[i] <= END_Y + 2 * speed) begin
          mAct[i] = 1'b0;
          ret++;
        end else begin
          mY[i] = mY[i] - speed;
`ifdef OBSTACLE_ANIMATION_EN
          if (mId[i] == 6) mId[i] = 7;
          else if (mId[i] == 7) mId[i] = 6;
`endif
        end
      end
    end
    mGap = (mGap + speed > 1023) ? 1023 : mGap + speed;
    thr  = MIN_GAP + (mLfsr % 16) * 8;
    freeSlot = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (!mAct[i]) freeSlot = i;
    end
    if (mGap >= thr && freeSlot >= 0) begin
      mAct[freeSlot] = 1'b1;
      mY[freeSlot]   = SPAWN_Y;
      mX[freeSlot]   = ((mLfsr % 2) == 1) ? 110 : 63;
      mId[freeSlot]  = ((mLfsr % 2) == 1) ? 8 : 6;
      mGap = 0;
    end
    mLfsr = galoisStep(mLfsr);
    mPc = (mPc + ret > 255) ? 255 : mPc + ret;
    e = snapshot(ret > 0);
  endtask

  // Monitor: a falling busy marks the end of a pass (or a reset abort).
  // Pop the prediction and compare the whole slot table.
  logic prevBusy = 1'b0;
  bit   pulseCheck = 1'b0;
  expT  monE;

  always @(negedge clock) begin
    if (pulseCheck) begin
      checkOutput("passed_one_clock", 64'(passed), 64'd0);
      pulseCheck = 1'b0;
    end
    if (prevBusy && !busy) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_pass_end: got pass end, expected none queued");
      end else begin
        monE = expQ.pop_front();
        checkOutput("xObstacle", 64'(xObstacle), 64'(monE.x));
        checkOutput("yObstacle", 64'(yObstacle), 64'(monE.y));
        checkOutput("IdObstacle", 64'(IdObstacle), 64'(monE.id));
        checkOutput("active", 64'(active), 64'(monE.act));
        checkOutput("passed", 64'(passed), 64'(monE.passed));
        checkOutput("passedCount", 64'(passedCount), 64'(monE.pc));
        pulseCheck = 1'b1;
      end
    end
    prevBusy = busy;
  end

  // Issue one tick, queue its prediction, and time the pass. With extra set,
  // stray ticks are driven during the pass and must not start another one.
  task automatic applyStimulus(input int speed, input bit extra);
    expT e;
    int  cnt;
    @(negedge clock);
    gameSpeed = 9'(speed);
    update    = 1'b1;
    modelPass(speed, e);
    expQ.push_back(e);
    @(negedge clock);
    cnt    = 1;
    update = extra;
    checkOutput("busy_rise", 64'(busy), 64'd1);
    while (busy && cnt < 64) begin
      @(negedge clock);
      cnt++;
      update = extra && (cnt == 2);
    end
    update = 1'b0;
    checkOutput("pass_latency", 64'(cnt), 64'(N + 3));
    if (extra) begin
      @(negedge clock);
      checkOutput("stray_update_ignored", 64'(busy), 64'd0);
    end
  endtask

  // Start a pass, then pull reset low while slots are still being moved
  task automatic applyMidPassReset(input int speed, input int newSeed);
    @(negedge clock);
    gameSpeed = 9'(speed);
    update    = 1'b1;
    expQ.push_back(resetRecord());
    @(negedge clock);
    update = 1'b0;
    @(negedge clock);
    reset      = 1'b0;
    randomSeed = 16'(newSeed);
    @(negedge clock);
    reset = 1'b1;
    modelReset(newSeed);
    checkOutput("busy_after_abort", 64'(busy), 64'd0);
    @(negedge clock);
  endtask

  // Watchdog so a stuck DUT still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected run to complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    expT rst;
    reset      = 1'b0;
    update     = 1'b0;
    gameSpeed  = 9'd0;
    randomSeed = 16'h0000;
    modelReset(0);

    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = resetRecord();
    checkOutput("reset_x", 64'(xObstacle), 64'(rst.x));
    checkOutput("reset_y", 64'(yObstacle), 64'(rst.y));
    checkOutput("reset_id", 64'(IdObstacle), 64'(rst.id));
    checkOutput("reset_active", 64'(active), 64'd0);
    checkOutput("reset_passed", 64'(passed), 64'd0);
    checkOutput("reset_passedCount", 64'(passedCount), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);

    reset = 1'b1;
    @(negedge clock);
    checkOutput("seed_busy", 64'(busy), 64'd0);

    $display("[TB] directed passes at speed 10");
    applyStimulus(10, 1'b0);
    applyStimulus(10, 1'b1);
    for (int k = 0; k < 44; k++) begin
      applyStimulus(10, 1'b0);
    end

    $display("[TB] randomised passes");
    for (int k = 0; k < 150; k++) begin
      int sp;
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) sp = 0;
      else if (sel == 1) sp = $urandom_range(300, 511);
      else if (sel < 8) sp = $urandom_range(15, 30);
      else sp = $urandom_range(5, 80);
      applyStimulus(sp, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("[TB] reset in the middle of a pass");
    applyMidPassReset(20, 'h1234);

    for (int k = 0; k < 60; k++) begin
      applyStimulus($urandom_range(10, 70), ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge clock);
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter NUM_OBSTACLES, default 3: number of concurrent obstacle slots, range 1..8.
REQ-002 Parameter SPAWN_Y, default 419: y position given to a newly spawned obstacle.
REQ-003 Parameter END_Y, default 36: left-edge retirement base.
REQ-004 Parameter MIN_GAP, default 120: minimum accumulated travel between consecutive spawns.
REQ-005 clock  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 update  in  1  one-clock game-tick pulse; starts one scheduling pass.
REQ-008 gameSpeed  in  9  pixels moved per tick, unsigned.
REQ-009 randomSeed  in  16  LFSR seed, sampled in SEED state.
REQ-010 xObstacle  out  8*NUM_OBSTACLES  packed per-slot lane (63 low, 110 high); slot i at bits [8i+7:8i].
REQ-011 yObstacle  out  9*NUM_OBSTACLES  packed per-slot y position.
REQ-012 IdObstacle  out  4*NUM_OBSTACLES  packed per-slot sprite Id.
REQ-013 active  out  NUM_OBSTACLES  slot-occupied flags.
REQ-014 passed  out  1  one-clock pulse at pass end if at least one slot retired.
REQ-015 passedCount  out  8  saturating count of retired obstacles.
REQ-016 busy  out  1  high while a scheduling pass is in progress.

Function
REQ-017 States: SEED, IDLE, MOVE, SPAWN, DONE; SEED entered only from reset.
REQ-018 SEED: load LFSR with randomSeed, or 16'hACE1 if randomSeed is zero; then IDLE.
REQ-019 IDLE: update high -> MOVE with slot index 0, busy high next clock.
REQ-020 MOVE: one slot per clock, index 0..NUM_OBSTACLES-1, then SPAWN.
REQ-021 Active slot: if old y <= END_Y + 2*gameSpeed (evaluated at 11-bit width, no overflow), clear active and count a retirement; otherwise y <= y - gameSpeed.
REQ-022 Inactive slot in MOVE: no change.
REQ-023 Gap accumulator, 10 bits, saturating: adds gameSpeed once per pass in SPAWN.
REQ-024 SPAWN: if accumulator >= MIN_GAP + {lfsr[3:0],3'b000} and a free slot exists, fill the lowest-index free slot: active=1, y=SPAWN_Y, lfsr[0]=1 -> x=110, Id=8; else x=63, Id=6; accumulator cleared.
REQ-025 A slot retired in the current pass is free for SPAWN in the same pass.
REQ-026 No free slot: no spawn; accumulator keeps saturating.
REQ-027 LFSR: 16-bit Galois, taps 16,14,13,11; advances exactly once per pass in SPAWN, after the threshold compare.
REQ-028 DONE: passed = 1 for one clock if retirements > 0; passedCount += retirements, saturating at 255; busy low; then IDLE.
REQ-029 Pass latency is NUM_OBSTACLES+3 clocks from update to DONE exit.
REQ-030 update while busy or in SEED: ignored, not queued.
REQ-031 gameSpeed is sampled per slot during MOVE; the bench holds it stable during a pass.

Reset
REQ-032 reset low at a clock edge, including mid-pass, forces: all x=63, y=SPAWN_Y, Id=8, active=0, passed=0, passedCount=0, busy=0, gap accumulator=1023 (first pass spawns), state SEED.

Configuration
REQ-033 Macro OBSTACLE_ANIMATION_EN defined: in MOVE, each surviving active slot with Id 6 toggles to 7, and Id 7 toggles to 6; Id 8 is unchanged.
REQ-034 Macro OBSTACLE_ANIMATION_EN undefined: Id holds its spawn value; no toggle logic is built.

Verification
REQ-035 Reset low 2 clocks, randomSeed=16'h0000 -> outputs per REQ-032; after SEED, LFSR=16'hACE1; busy=0.
REQ-036 gameSpeed=10, first update -> slot0 active, y=419, x/Id per lfsr[0]; busy high exactly NUM_OBSTACLES+3 clocks; passed=0.
REQ-037 One active slot, speed 10, y stepping 419, 409, ... -> on the pass where old y=59, y=49; next pass (old y=49 <= 56) retires the slot, passed pulses once, passedCount=1.
REQ-038 All 3 slots active, threshold met -> no spawn, accumulator saturates at 1023; slot freed next pass -> spawn into that index in the same pass.
REQ-039 update pulsed on clocks 2 and 3 of a pass -> ignored; exactly one pass. reset low mid-MOVE -> REQ-032 state on the next clock.
REQ-040 Low obstacle with OBSTACLE_ANIMATION_EN defined -> Id sequence 6, 7, 6 over passes; macro undefined -> Id stays 6.
